trivium_seq: RTL and testbench

Sequencer for the Trivium stream cipher. It loads an 80-bit key and an 80-bit IV into the 288-bit state and runs the 1152-round warm-up. It then produces a caller-requested number of keystream words over a valid/ready output handshake. It sits between the host register interface and the XOR stage that consumes keystream.

---
 rtl/trivium_pkg.sv | 29 ++
 rtl/trivium_round.sv | 32 +++
 rtl/trivium_seq.sv | 176 +++++++++++++++++
 tb/tb_trivium_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared constants, tap positions, FSM encodings and the key/IV byte-reverse
// helper for the Trivium keystream sequencer.
package trivium_pkg;

    localparam int KEY_W       = 80;
    localparam int IV_W        = 80;
    localparam int STATE_W     = 288;
    localparam int INIT_ROUNDS = 1152;

    // Linear taps, AND-pair taps and cross-register feedback tap per register
    localparam int T1_A = 65,  T1_B = 92,  T1_N0 = 90,  T1_N1 = 91,  T1_FB = 170;
    localparam int T2_A = 161, T2_B = 176, T2_N0 = 174, T2_N1 = 175, T2_FB = 263;
    localparam int T3_A = 242, T3_B = 287, T3_N0 = 285, T3_N1 = 286, T3_FB = 68;

    // FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_GEN  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Reverse byte order: v[7:0] ends up in the top byte of the result
    function automatic logic [KEY_W-1:0] byte_rev80(input logic [KEY_W-1:0] v);
        logic [KEY_W-1:0] r;
        for (int i = 0; i < KEY_W / 8; i++)
            r[8*i +: 8] = v[8*(KEY_W/8-1-i) +: 8];
        return r;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// Combinational Trivium core: UNROLL chained rounds per evaluation.
// z_o[UNROLL-1] is the keystream bit of the first (oldest) round.
module trivium_round
    import trivium_pkg::*;
#(
    parameter int UNROLL = 8
) (
    input  logic [STATE_W-1:0] s_i,
    output logic [STATE_W-1:0] s_o,
    output logic [UNROLL-1:0]  z_o
);

    logic [UNROLL:0][STATE_W-1:0] st;

    assign st[0] = s_i;

    for (genvar r = 0; r < UNROLL; r++) begin : g_rnd
        logic t1, t2, t3, f1, f2, f3;
        assign t1 = st[r][T1_A] ^ st[r][T1_B];
        assign t2 = st[r][T2_A] ^ st[r][T2_B];
        assign t3 = st[r][T3_A] ^ st[r][T3_B];
        assign z_o[UNROLL-1-r] = t1 ^ t2 ^ t3;
        assign f1 = t1 ^ (st[r][T1_N0] & st[r][T1_N1]) ^ st[r][T1_FB];
        assign f2 = t2 ^ (st[r][T2_N0] & st[r][T2_N1]) ^ st[r][T2_FB];
        assign f3 = t3 ^ (st[r][T3_N0] & st[r][T3_N1]) ^ st[r][T3_FB];
        // each of the three registers shifts up by one, feedback enters at its base
        assign st[r+1] = {st[r][286:177], f2, st[r][175:93], f1, st[r][91:0], f3};
    end

    assign s_o = st[UNROLL];

endmodule

// File: rtl/trivium_seq.sv
// Trivium sequencer: key/IV load, 1152-round warm-up, then Nwords keystream
// words over a Dvld/Dack handshake. Optional macro TRIVIUM_STATUS_EN adds the
// Wrem remaining-word output.
module trivium_seq
    import trivium_pkg::*;
#(
    parameter int UNROLL = 8,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic [KEY_W-1:0]  Kin,
    input  logic [IV_W-1:0]   IVin,
    input  logic [15:0]       Nwords,
    input  logic              Krdy,
    input  logic              Abort,
    input  logic              Dack,
    output logic              BSY,
    output logic              Kvld,
    output logic [WORD_W-1:0] Dout,
    output logic              Dvld,
    output logic              Done
`ifdef TRIVIUM_STATUS_EN
   ,output logic [15:0]       Wrem
`endif
);

    localparam int         WPC      = WORD_W / UNROLL;
    localparam int         BIT_W    = (WPC > 1) ? $clog2(WPC) : 1;
    localparam logic [10:0] RND_LAST = 11'(INIT_ROUNDS / UNROLL - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WPC - 1);

    logic [1:0]         st_q, st_d;
    logic [STATE_W-1:0] s_q, s_d, s_nxt, s_load;
    logic [UNROLL-1:0]  z;
    logic [10:0]        rnd_q, rnd_d;
    logic               warm_q, warm_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d, word_nxt;
    logic [15:0]        wcnt_q, wcnt_d;
    logic [WORD_W-1:0]  dout_q, dout_d;
    logic               dvld_q, dvld_d;
    logic               kvld_q, kvld_d;
    logic               done_q, done_d;

    trivium_round #(.UNROLL(UNROLL)) u_round (
        .s_i (s_q),
        .s_o (s_nxt),
        .z_o (z)
    );

    assign s_load = {3'b111, 112'b0, byte_rev80(IVin), 13'b0, byte_rev80(Kin)};

    // Oldest bits sit toward the MSB, so fresh z bits enter at the bottom
    if (WORD_W == UNROLL) begin : g_word_one
        assign word_nxt = z;
    end else begin : g_word_shift
        assign word_nxt = {shreg_q[WORD_W-UNROLL-1:0], z};
    end

    // Next-state logic; Abort overrides everything, pulses default low
    always_comb begin
        st_d    = st_q;
        s_d     = s_q;
        rnd_d   = rnd_q;
        warm_d  = warm_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        wcnt_d  = wcnt_q;
        dout_d  = dout_q;
        dvld_d  = dvld_q;
        kvld_d  = 1'b0;
        done_d  = 1'b0;
        if (Abort) begin
            st_d   = ST_IDLE;
            dvld_d = 1'b0;
            wcnt_d = '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (Krdy) begin
                        s_d    = s_load;
                        wcnt_d = Nwords;
                        rnd_d  = '0;
                        warm_d = 1'b0;
                        bit_d  = '0;
                        st_d   = ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (!warm_q) begin
                        // warm-up rounds, keystream discarded
                        s_d = s_nxt;
                        if (rnd_q == RND_LAST) warm_d = 1'b1;
                        else                   rnd_d  = rnd_q + 11'd1;
                    end else begin
                        // warm-up finished last cycle: announce it
                        kvld_d = 1'b1;
                        bit_d  = '0;
                        if (wcnt_q == 16'd0) begin
                            done_d = 1'b1;
                            st_d   = ST_IDLE;
                        end else begin
                            st_d = ST_GEN;
                        end
                    end
                end
                ST_GEN: begin
                    s_d     = s_nxt;
                    shreg_d = word_nxt;
                    if (bit_q == BIT_LAST) begin
                        dout_d = word_nxt;
                        dvld_d = 1'b1;
                        bit_d  = '0;
                        st_d   = ST_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
                default: begin
                    // ST_HOLD: cipher state frozen until the word is taken
                    if (Dack) begin
                        dvld_d = 1'b0;
                        wcnt_d = wcnt_q - 16'd1;
                        if (wcnt_q == 16'd1) begin
                            done_d = 1'b1;
                            st_d   = ST_IDLE;
                        end else begin
                            st_d = ST_GEN;
                        end
                    end
                end
            endcase
        end
    end

    // State registers; EN low freezes everything including pending pulses
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st_q    <= ST_IDLE;
            s_q     <= '0;
            rnd_q   <= '0;
            warm_q  <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
            wcnt_q  <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            kvld_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (EN) begin
            st_q    <= st_d;
            s_q     <= s_d;
            rnd_q   <= rnd_d;
            warm_q  <= warm_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            wcnt_q  <= wcnt_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            kvld_q  <= kvld_d;
            done_q  <= done_d;
        end
    end

    assign BSY  = (st_q != ST_IDLE);
    assign Kvld = kvld_q;
    assign Dout = dout_q;
    assign Dvld = dvld_q;
    assign Done = done_q;
`ifdef TRIVIUM_STATUS_EN
    assign Wrem = wcnt_q;
`endif

endmodule

// File: tb/tb_trivium_seq.sv
// Directed bench for trivium_seq (UNROLL=8, WORD_W=32) with a bit-serial
// reference model written in the classic 1-based s1..s288 notation.
module tb_trivium_seq;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        EN;
    logic [79:0] Kin;
    logic [79:0] IVin;
    logic [15:0] Nwords;
    logic        Krdy;
    logic        Abort;
    logic        Dack;
    logic        BSY;
    logic        Kvld;
    logic [31:0] Dout;
    logic        Dvld;
    logic        Done;
`ifdef TRIVIUM_STATUS_EN
    logic [15:0] Wrem;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    trivium_seq #(.UNROLL(8), .WORD_W(32)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .EN     (EN),
        .Kin    (Kin),
        .IVin   (IVin),
        .Nwords (Nwords),
        .Krdy   (Krdy),
        .Abort  (Abort),
        .Dack   (Dack),
        .BSY    (BSY),
        .Kvld   (Kvld),
        .Dout   (Dout),
        .Dvld   (Dvld),
        .Done   (Done)
`ifdef TRIVIUM_STATUS_EN
       ,.Wrem   (Wrem)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference keystream: standard Trivium update on s[1..288]
    task automatic model_run(input logic [79:0] k, input logic [79:0] iv, input int nw);
        bit s [1:288];
        bit t1, t2, t3, z;
        logic [79:0] kp, ivp;
        logic [31:0] w;
        int nb;
        for (int b = 0; b < 10; b++) begin
            kp[79-8*b -: 8]  = k[8*b +: 8];
            ivp[79-8*b -: 8] = iv[8*b +: 8];
        end
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            s[i+1]  = kp[i];
            s[94+i] = ivp[i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        exp_q.delete();
        w  = '0;
        nb = 0;
        for (int r = 0; r < 1152 + nw * 32; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i >= 2; i--) s[i] = s[i-1];
            s[1]   = t3;
            s[94]  = t1;
            s[178] = t2;
            if (r >= 1152) begin
                w = {w[30:0], z};
                nb++;
                if (nb == 32) begin
                    exp_q.push_back(w);
                    nb = 0;
                end
            end
        end
    endtask

    // Start a job at edge 0 and observe until Done or the cycle limit.
    // hold: cycles Dack stays low on the first word; tog: EN on even edges only;
    // abort_at: edge at which Abort is applied (-1 for none).
    task automatic run_job(input logic [79:0] k, input logic [79:0] iv, input logic [15:0] nw,
                           input int hold, input bit tog, input int abort_at, input int limit,
                           output int kv_c, output int dn_c, output int unstable,
                           output logic bsy0, output logic bsy_end);
        int cyc;
        int held_cnt;
        logic [31:0] held;
        got_q.delete();
        kv_c = -1; dn_c = -1; unstable = 0; held_cnt = 0; held = '0;
        bsy0 = 1'b0; bsy_end = 1'b1;
        @(negedge CLK);
        Kin = k; IVin = iv; Nwords = nw; Krdy = 1'b1; EN = 1'b1; Dack = 1'b1; Abort = 1'b0;
        @(posedge CLK);
        cyc = 0;
        while (1) begin
            @(negedge CLK);
            Krdy = 1'b0;
            if (cyc == 0) bsy0 = BSY;
            if (Kvld && kv_c < 0) kv_c = cyc;
            if (Done && dn_c < 0) dn_c = cyc;
            bsy_end = BSY;
            if (dn_c >= 0 || cyc >= limit) break;
            EN    = tog ? ((cyc + 1) % 2 == 0) : 1'b1;
            Abort = (cyc + 1 == abort_at);
            Dack  = 1'b1;
            if (Dvld) begin
                if (held_cnt == 0) held = Dout;
                else if (held_cnt <= hold && Dout !== held) unstable++;
                if (held_cnt < hold) Dack = 1'b0;
                if (held_cnt <= hold) held_cnt++;
                if (Dack && EN) got_q.push_back(Dout);
            end
            @(posedge CLK);
            cyc++;
        end
        Abort = 1'b0; EN = 1'b1; Dack = 1'b1;
    endtask

    task automatic chk_words(input string tag, input int nw);
        chk({tag, "_cnt"}, 64'(got_q.size()), 64'(nw));
        for (int i = 0; i < nw; i++)
            chk($sformatf("%s_w%0d", tag, i),
                (i < got_q.size()) ? {32'h0, got_q[i]} : 64'hx, {32'h0, exp_q[i]});
    endtask

    initial begin
        int kv, dn, ust, wt;
        logic b0, be;
        logic [31:0] ref_w [$];
        RSTn = 1'b0; EN = 1'b1; Kin = '0; IVin = '0; Nwords = '0;
        Krdy = 1'b0; Abort = 1'b0; Dack = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_bsy", BSY, 0);
        chk("rst_kvld", Kvld, 0);
        chk("rst_dvld", Dvld, 0);
        chk("rst_done", Done, 0);
        chk("rst_dout", Dout, 0);
        RSTn = 1'b1;

        // zero key/IV, 4 words, Dack always high
        model_run(80'h0, 80'h0, 4);
        run_job(80'h0, 80'h0, 16'd4, 0, 1'b0, -1, 2000, kv, dn, ust, b0, be);
        chk("t1_bsy0", b0, 1);
        chk("t1_kvld_cyc", 64'(kv), 64'(145));
        chk("t1_done_cyc", 64'(dn), 64'(165));
        chk("t1_bsy_end", be, 0);
        chk_words("t1", 4);
        ref_w = got_q;

        // Dack held low for 10 cycles on the first word
        model_run(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 2);
        run_job(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16'd2, 10, 1'b0, -1, 2000,
                kv, dn, ust, b0, be);
        chk("t2_stable", 64'(ust), 64'(0));
        chk("t2_done_cyc", 64'(dn), 64'(165));
        chk_words("t2", 2);

        // zero words requested
        run_job(80'h11223344556677889900, 80'h0, 16'd0, 0, 1'b0, -1, 2000, kv, dn, ust, b0, be);
        chk("t3_kvld_cyc", 64'(kv), 64'(145));
        chk("t3_done_cyc", 64'(dn), 64'(145));
        chk("t3_nodvld", 64'(got_q.size()), 64'(0));
        chk("t3_bsy_end", be, 0);

        // abort at edge 50 of warm-up, then a fresh run
        run_job(80'hAAAA5555AAAA5555AAAA, 80'h1, 16'd3, 0, 1'b0, 50, 250, kv, dn, ust, b0, be);
        chk("t4_no_kvld", 64'(kv), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_no_done", 64'(dn), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_bsy_end", be, 0);
        model_run(80'hDEADBEEFCAFEF00D1234, 80'h00FF00FF00FF00FF00FF, 2);
        run_job(80'hDEADBEEFCAFEF00D1234, 80'h00FF00FF00FF00FF00FF, 16'd2, 0, 1'b0, -1, 2000,
                kv, dn, ust, b0, be);
        chk("t4_kvld_cyc", 64'(kv), 64'(145));
        chk_words("t4", 2);

        // EN toggling: same words, twice the cycles
        model_run(80'h0, 80'h0, 4);
        run_job(80'h0, 80'h0, 16'd4, 0, 1'b1, -1, 4000, kv, dn, ust, b0, be);
        chk("t5_kvld_cyc", 64'(kv), 64'(290));
        chk("t5_done_cyc", 64'(dn), 64'(330));
        chk_words("t5", 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5_same%0d", i),
                (i < got_q.size() && i < ref_w.size()) ? {32'h0, got_q[i]} : 64'hx,
                (i < ref_w.size()) ? {32'h0, ref_w[i]} : 64'h0);

        // asynchronous reset while a word is waiting
        @(negedge CLK);
        Kin = 80'h0102030405060708090A; IVin = 80'h0; Nwords = 16'd4; Krdy = 1'b1; Dack = 1'b0;
        @(negedge CLK);
        Krdy = 1'b0;
        wt = 0;
        while (!Dvld && wt < 400) begin
            @(negedge CLK);
            wt++;
        end
        chk("t6_dvld_seen", Dvld, 1);
        #2 RSTn = 1'b0;
        #1;
        chk("t6_dvld", Dvld, 0);
        chk("t6_bsy", BSY, 0);
        chk("t6_dout", Dout, 0);
        @(negedge CLK);
        RSTn = 1'b1; Dack = 1'b1;
        model_run(80'h0102030405060708090A, 80'hCAFE, 1);
        run_job(80'h0102030405060708090A, 80'hCAFE, 16'd1, 0, 1'b0, -1, 2000, kv, dn, ust, b0, be);
        chk("t6_kvld_cyc", 64'(kv), 64'(145));
        chk("t6_done_cyc", 64'(dn), 64'(150));
        chk_words("t6", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
